cmp_sort_ctrl: RTL and testbench

Sequential sorter that accepts N bytes over a valid/ready input stream and sorts them in place with one shared instance of the team's 8-bit comparator (`Comp8bit`, outputs le/eq/gr). It then emits them in ascending order over a valid/ready output stream. A three-state controller schedules exactly one comparison per cycle. The block sits between a byte producer and consumer wherever small ordered sets are needed, such as median or priority selection.

---
 rtl/cmp_sort_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_cmp_sort_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_sort_ctrl.sv
// cmp_sort_ctrl: sequential in-place sorter for N unsigned bytes.
// A frame of N bytes is loaded over a valid/ready stream, bubble-sorted with a
// single shared Comp8bit (one compare per cycle), then streamed out in
// ascending order. dup_o flags a frame that holds at least one repeated value.
// Optional feature macro: CMP_SORT_EARLY_EXIT_EN. When defined, sorting stops
// at the end of the first pass that performs no swap. When undefined, exactly
// N-1 full passes always run, so the latency is a fixed (N-1)^2 cycles.

// Shared 8-bit unsigned magnitude comparator. le means strictly less;
// exactly one of le/eq/gr is high for any input pair.
module Comp8bit (
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    output logic       le,
    output logic       eq,
    output logic       gr
);
    assign le = (in1 <  in2);
    assign eq = (in1 == in2);
    assign gr = (in1 >  in2);
endmodule

module cmp_sort_ctrl #(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_data_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_data_o,
    output logic       out_last_o,
    output logic       dup_o,
    output logic       busy_o
);
    // Counters carry one spare bit so that none of them can wrap.
    localparam int CW = $clog2(N) + 1;
    localparam int IW = $clog2(N);

    localparam logic [CW-1:0] LAST_IDX  = CW'(N - 1);
    localparam logic [CW-1:0] PASS_END  = CW'(N - 2);
    localparam logic [CW-1:0] LAST_PASS = CW'(N - 2);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      data_q [N];
    logic [7:0]      data_d [N];
    logic [CW-1:0]   widx_q, widx_d;
    logic [CW-1:0]   ridx_q, ridx_d;
    logic [CW-1:0]   j_q, j_d;
    logic [CW-1:0]   p_q, p_d;
    logic            dup_q, dup_d;
    logic            in_ready_q, in_ready_d;
`ifdef CMP_SORT_EARLY_EXIT_EN
    logic            swapped_q, swapped_d;
`endif

    logic [CW-1:0]   j_plus1;
    logic [IW-1:0]   j_idx;
    logic [IW-1:0]   j1_idx;
    logic [7:0]      cmp_a;
    logic [7:0]      cmp_b;
    logic            cmp_le;
    logic            cmp_eq;
    logic            cmp_gr;
    logic            swap_en;

    assign j_plus1 = j_q + CW'(1);
    assign j_idx   = j_q[IW-1:0];
    assign j1_idx  = j_plus1[IW-1:0];
    assign cmp_a   = data_q[j_idx];
    assign cmp_b   = data_q[j1_idx];

    Comp8bit u_cmp (
        .in1 (cmp_a),
        .in2 (cmp_b),
        .le  (cmp_le),
        .eq  (cmp_eq),
        .gr  (cmp_gr)
    );

    // Swap only on strictly greater; equal pairs stay put, keeping the sort stable.
    assign swap_en = cmp_gr & ~(cmp_le | cmp_eq);

    // Next-state logic: load, one compare/swap per cycle, then drain.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        widx_d  = widx_q;
        ridx_d  = ridx_q;
        j_d     = j_q;
        p_d     = p_q;
        dup_d   = dup_q;
`ifdef CMP_SORT_EARLY_EXIT_EN
        swapped_d = swapped_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (in_valid_i && in_ready_q) begin
                    data_d[widx_q[IW-1:0]] = in_data_i;
                    if (widx_q == LAST_IDX) begin
                        widx_d  = '0;
                        j_d     = '0;
                        p_d     = '0;
                        dup_d   = 1'b0;
`ifdef CMP_SORT_EARLY_EXIT_EN
                        swapped_d = 1'b0;
`endif
                        state_d = ST_SORT;
                    end else begin
                        widx_d = widx_q + CW'(1);
                    end
                end
            end
            ST_SORT: begin
                if (swap_en) begin
                    data_d[j_idx]  = cmp_b;
                    data_d[j1_idx] = cmp_a;
`ifdef CMP_SORT_EARLY_EXIT_EN
                    swapped_d = 1'b1;
`endif
                end
                if (cmp_eq) begin
                    dup_d = 1'b1;
                end
                if (j_q == PASS_END) begin
                    j_d = '0;
                    p_d = p_q + CW'(1);
`ifdef CMP_SORT_EARLY_EXIT_EN
                    swapped_d = 1'b0;
                    // A pass with no swap (including this last compare) means sorted.
                    if ((p_q == LAST_PASS) || !(swapped_q || swap_en)) begin
                        ridx_d  = '0;
                        state_d = ST_OUT;
                    end
`else
                    if (p_q == LAST_PASS) begin
                        ridx_d  = '0;
                        state_d = ST_OUT;
                    end
`endif
                end else begin
                    j_d = j_plus1;
                end
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    if (ridx_q == LAST_IDX) begin
                        ridx_d  = '0;
                        widx_d  = '0;
                        dup_d   = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        ridx_d = ridx_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        // Registered so in_ready stays low through reset and rises on the first edge after it.
        in_ready_d = (state_d == ST_LOAD);
    end

    // State, counters and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD;
            widx_q     <= '0;
            ridx_q     <= '0;
            j_q        <= '0;
            p_q        <= '0;
            dup_q      <= 1'b0;
            in_ready_q <= 1'b0;
`ifdef CMP_SORT_EARLY_EXIT_EN
            swapped_q  <= 1'b0;
`endif
            for (int i = 0; i < N; i++) begin
                data_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            widx_q     <= widx_d;
            ridx_q     <= ridx_d;
            j_q        <= j_d;
            p_q        <= p_d;
            dup_q      <= dup_d;
            in_ready_q <= in_ready_d;
`ifdef CMP_SORT_EARLY_EXIT_EN
            swapped_q  <= swapped_d;
`endif
            for (int i = 0; i < N; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = (state_q == ST_OUT);
    assign out_data_o  = out_valid_o ? data_q[ridx_q[IW-1:0]] : 8'h00;
    assign out_last_o  = out_valid_o && (ridx_q == LAST_IDX);
    assign dup_o       = out_valid_o && dup_q;
    assign busy_o      = (state_q != ST_LOAD);

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Directed testbench for cmp_sort_ctrl (N=4). Expected sorted frames,
// duplicate flags and sort latencies are hand-computed constants; latencies
// that depend on CMP_SORT_EARLY_EXIT_EN are selected with the same macro.
module tb_cmp_sort_ctrl;

`ifdef CMP_SORT_EARLY_EXIT_EN
    localparam int SORTED_LAT = 3;
`else
    localparam int SORTED_LAT = 9;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       dup;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    cmp_sort_ctrl #(.N(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .dup_o       (dup),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance one clock; everything is sampled and driven 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [7:0] v [4], input string name);
        int guard;
        for (int i = 0; i < 4; i++) begin
            guard    = 0;
            in_valid = 1'b1;
            in_data  = v[i];
            while (!in_ready && guard < 20) begin
                step();
                guard++;
            end
            check({name, "_in_ready_at_accept"}, 32'(in_ready), 32'd1);
            $display("%s: load byte %0d = %0d", name, i, v[i]);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_sort(input int exp_lat, input bit junk, input string name);
        int cnt;
        cnt = 0;
        check({name, "_in_ready_fall"}, 32'(in_ready), 32'd0);
        check({name, "_busy_sort"}, 32'(busy), 32'd1);
        if (junk) begin
            in_valid = 1'b1;
            in_data  = 8'hAA;
        end
        while (!out_valid && cnt < 200) begin
            step();
            cnt++;
        end
        in_valid = 1'b0;
        check({name, "_sort_latency"}, 32'(cnt), 32'(exp_lat));
    endtask

    task automatic drain(input logic [7:0] exp [4], input logic exp_dup, input bit stall,
                         input string name);
        int idx;
        int k;
        idx = 0;
        k   = 0;
        while (idx < 4 && k < 60) begin
            bit rdy;
            rdy = stall ? ((k >= 5) && (((k - 5) % 2) == 0)) : 1'b1;
            out_ready = rdy;
            check({name, "_out_valid"}, 32'(out_valid), 32'd1);
            check({name, "_out_data"},  32'(out_data),  32'(exp[idx]));
            check({name, "_out_last"},  32'(out_last),  32'(idx == 3));
            check({name, "_dup"},       32'(dup),       32'(exp_dup));
            check({name, "_in_ready_out"}, 32'(in_ready), 32'd0);
            if (rdy) begin
                $display("%s: out byte %0d = %0d last=%0b dup=%0b", name, idx, out_data,
                         out_last, dup);
            end
            step();
            k++;
            if (rdy) idx++;
        end
        out_ready = 1'b0;
        check({name, "_out_count"},  32'(idx),       32'd4);
        check({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
        check({name, "_out_valid_end"}, 32'(out_valid), 32'd0);
        check({name, "_busy_end"},   32'(busy),      32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"},  32'(in_ready),  32'd0);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_out_data"},  32'(out_data),  32'd0);
        check({name, "_out_last"},  32'(out_last),  32'd0);
        check({name, "_dup"},       32'(dup),       32'd0);
        check({name, "_busy"},      32'(busy),      32'd0);
    endtask

    initial begin
        // Reset state and in_ready rising on the first edge after release.
        rst_n = 1'b0;
        step();
        step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_hold", 32'(in_ready), 32'd0);
        step();
        check("rst_in_ready_rise", 32'(in_ready), 32'd1);

        // Reverse order.
        load_frame('{8'd9, 8'd5, 8'd2, 8'd1}, "rev");
        wait_sort(9, 1'b0, "rev");
        drain('{8'd1, 8'd2, 8'd5, 8'd9}, 1'b0, 1'b0, "rev");

        // Duplicates.
        load_frame('{8'd5, 8'd1, 8'd5, 8'd0}, "dupf");
        wait_sort(9, 1'b0, "dupf");
        drain('{8'd0, 8'd1, 8'd5, 8'd5}, 1'b1, 1'b0, "dupf");

        // Already sorted.
        load_frame('{8'd1, 8'd2, 8'd3, 8'd4}, "sorted");
        wait_sort(SORTED_LAT, 1'b0, "sorted");
        drain('{8'd1, 8'd2, 8'd3, 8'd4}, 1'b0, 1'b0, "sorted");

        // Backpressure: 5 stalled cycles, then out_ready toggles.
        load_frame('{8'd200, 8'd7, 8'd255, 8'd0}, "bp");
        wait_sort(9, 1'b0, "bp");
        drain('{8'd0, 8'd7, 8'd200, 8'd255}, 1'b0, 1'b1, "bp");

        // Junk input while busy must not be stored.
        load_frame('{8'd3, 8'd8, 8'd8, 8'd1}, "junk");
        wait_sort(9, 1'b1, "junk");
        drain('{8'd1, 8'd3, 8'd8, 8'd8}, 1'b1, 1'b0, "junk");

        // Reset during the second pass, then a fresh all-equal frame.
        load_frame('{8'd9, 8'd5, 8'd2, 8'd1}, "mid");
        for (int i = 0; i < 4; i++) step();
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("midrst_in_ready_hold", 32'(in_ready), 32'd0);
        step();
        check("midrst_in_ready_rise", 32'(in_ready), 32'd1);
        load_frame('{8'd3, 8'd3, 8'd3, 8'd3}, "fresh");
        wait_sort(SORTED_LAT, 1'b0, "fresh");
        drain('{8'd3, 8'd3, 8'd3, 8'd3}, 1'b1, 1'b0, "fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
